// File: rtl/uart_rx_frame.sv
// UART receive frame engine: synchronizes rx, samples start/data/stop on baud ticks, delivers bytes on valid/ready.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 baud_tick,
  output logic                 baud_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_prev;
  logic [2:0]           state;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 tick;

  // Ticks are only meaningful while the generator is enabled.
  assign tick = baud_tick & baud_en;
  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      baud_en     <= 1'b0;
      bit_cnt     <= 3'd0;
      shift       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state   <= START;
            baud_en <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end else begin
              state   <= IDLE;
              baud_en <= 1'b0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_cnt == LAST_BIT) state <= PARITY;
`else
            if (bit_cnt == LAST_BIT) state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) state <= STOP;
        end
`endif
        STOP: begin
          if (tick) begin
            state   <= IDLE;
            baud_en <= 1'b0;
            // A same-cycle accept frees the holding register, so the new byte loads.
            if (!rx_s) begin
              frame_error <= 1'b1;
            end else if (rx_valid && !rx_ready) begin
              overrun <= 1'b1;
            end else begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          baud_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_mismatch;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      par_mismatch <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      parity_error <= 1'b0;
      if (tick && state == PARITY) par_mismatch <= rx_s ^ even_parity(shift);
      // Report only when the byte is actually delivered.
      if (tick && state == STOP && rx_s && !(rx_valid && !rx_ready))
        parity_error <= par_mismatch;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: directed scenarios plus random frames against a frame-level model.
module tb_uart_rx_frame;
  localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAST_TICK = DB + PB + 1;
  localparam int BIT_T = 16;
  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_OVR   = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b0;
  logic          baud_tick, baud_en, rx_valid, frame_error, parity_error, overrun, busy;
  logic [DB-1:0] rx_data;
  logic [3:0]    bcnt = 4'd0;
  logic [4:0]    tick_num = 5'd0;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       perr;
    logic       vld;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;

  uart_rx_frame #(.DATA_BITS(DB)) dut (
    .clock(clock), .reset_n(reset_n), .rx(rx), .baud_tick(baud_tick),
    .baud_en(baud_en), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_error(frame_error), .parity_error(parity_error), .overrun(overrun), .busy(busy)
  );

  always #5 clock = ~clock;

  // Baud generator model: first tick 8 cycles after enable, then every 16.
  assign baud_tick = baud_en && (bcnt == 4'd7);
  always @(posedge clock) begin
    if (!baud_en) begin
      bcnt     <= 4'd0;
      tick_num <= 5'd0;
    end else begin
      bcnt <= bcnt + 4'd1;
      if (baud_tick) tick_num <= tick_num + 5'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic par_of(input logic [7:0] d);
    logic p = 1'b0;
    for (int i = 0; i < DB; i++) p ^= d[i];
    return p;
  endfunction

  task automatic ack();
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    check("ack_clears_valid", rx_valid, 1'b0);
    m_valid = 1'b0;
  endtask

  // mode: 0/1 = ready low at stop, 2 = ready asserted exactly on the stop tick.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par,
                            input int mode, input bit hold_low, input int abort_bit);
    ev_t        e;
    logic [7:0] d;
    d = data & 8'((1 << DB) - 1);
    if (abort_bit < 0) begin
      e.data = d;
      e.perr = (PB == 1) && (par != par_of(d));
      e.vld  = 1'b0;
      if (!stop) begin
        if (mode == 2) m_valid = 1'b0;
        e.kind = K_FERR;
        e.vld  = m_valid;
        e.perr = 1'b0;
      end else if (m_valid && mode != 2) begin
        e.kind = K_OVR;
        e.data = m_data;
        e.perr = 1'b0;
      end else begin
        e.kind  = K_VALID;
        m_valid = 1'b1;
        m_data  = d;
      end
      exp_q.push_back(e);
    end
    rx = 1'b0;
    step(BIT_T);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      if (i == abort_bit) begin
        step(8);
        reset_n = 1'b0;
        rx = 1'b1;
        step(1);
        check("rst_baud_en", baud_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        step(3);
        reset_n = 1'b1;
        m_valid = 1'b0;
        step(4);
        return;
      end
      step(BIT_T);
    end
    if (PB == 1) begin
      rx = par;
      step(BIT_T);
    end
    rx = stop;
    for (int i = 0; i < BIT_T; i++) begin
      step(1);
      rx_ready = (mode == 2) && baud_tick && (tick_num == 5'(LAST_TICK));
    end
    rx_ready = 1'b0;
    if (!hold_low) begin
      rx = 1'b1;
      step(4);
    end
  endtask

  initial begin : monitor
    logic valid_prev;
    logic acc_prev;
    logic deliver;
    ev_t  e;
    valid_prev = 1'b0;
    acc_prev   = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        valid_prev = 1'b0;
        acc_prev   = 1'b0;
      end else begin
        deliver = rx_valid && (!valid_prev || acc_prev);
        if (frame_error || overrun || deliver) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: ferr=%0b ovr=%0b deliver=%0b data=%0h with nothing expected",
                     frame_error, overrun, deliver, rx_data);
          end else begin
            e = exp_q.pop_front();
            check("event_kind", frame_error ? K_FERR : (overrun ? K_OVR : K_VALID), e.kind);
            if (e.kind == K_VALID) begin
              check("rx_data", rx_data, e.data);
              check("parity_error", parity_error, e.perr);
            end else if (e.kind == K_OVR) begin
              check("ovr_held_data", rx_data, e.data);
              check("ovr_valid", rx_valid, 1'b1);
            end else begin
              check("ferr_valid", rx_valid, e.vld);
            end
          end
        end else if (parity_error) begin
          checks++;
          failures++;
          $display("FAIL stray_parity_error: got 1 expected 0");
        end
        valid_prev = rx_valid;
        acc_prev   = rx_valid && rx_ready;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic       st, pb;
    int         md;
    reset_n = 1'b0;
    step(3);
    check("reset_baud_en", baud_en, 1'b0);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_error", frame_error, 1'b0);
    check("reset_parity_error", parity_error, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_busy", busy, 1'b0);
    reset_n = 1'b1;
    step(4);

    send_frame(8'hA5, 1'b1, par_of(8'hA5), 1, 1'b0, -1);
    step(20);
    check("basic_valid_held", rx_valid, 1'b1);
    check("basic_data_held", rx_data, 8'hA5);
    ack();

    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(3);
    check("false_start_busy", busy, 1'b1);
    step(20);
    check("false_start_idle", busy, 1'b0);
    check("false_start_baud_en", baud_en, 1'b0);
    check("false_start_no_valid", rx_valid, 1'b0);

    send_frame(8'h3C, 1'b0, par_of(8'h3C), 1, 1'b1, -1);
    step(40);
    check("ferr_hold_low_busy", busy, 1'b0);
    check("ferr_hold_low_baud_en", baud_en, 1'b0);
    check("ferr_no_valid", rx_valid, 1'b0);
    rx = 1'b1;
    step(4);
    send_frame(8'h3C, 1'b1, par_of(8'h3C), 1, 1'b0, -1);
    ack();

    send_frame(8'h11, 1'b1, par_of(8'h11), 1, 1'b0, -1);
    send_frame(8'h22, 1'b1, par_of(8'h22), 1, 1'b0, -1);
    check("ovr_data_kept", rx_data, 8'h11);
    send_frame(8'h22, 1'b1, par_of(8'h22), 2, 1'b0, -1);
    check("same_cycle_valid", rx_valid, 1'b1);
    check("same_cycle_data", rx_data, 8'h22);
    ack();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1, 1'b0, -1);
    ack();
    send_frame(8'h07, 1'b1, 1'b0, 1, 1'b0, -1);
    check("parity_bad_data", rx_data, 8'h07);
    ack();
`endif

    send_frame(8'h5A, 1'b1, par_of(8'h5A), 1, 1'b0, 4);
    send_frame(8'h5A, 1'b1, par_of(8'h5A), 1, 1'b0, -1);
    check("after_reset_data", rx_data, 8'h5A);
    ack();

    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 5) != 0);
      pb = par_of(d) ^ ($urandom_range(0, 3) == 0);
      md = int'($urandom_range(0, 2));
      send_frame(d, st, pb, md, 1'b0, -1);
      if (md == 0 && m_valid) ack();
      step(int'($urandom_range(0, 6)));
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
